dma_desc_hdr_regs: RTL and testbench

- Descriptor header table register file for one DMA direction (one instance for read DMA, one for write DMA) in the chaining DMA design example.
- Directly downstream of the BAR2/3 register-access decoder. It consumes dma_prg_addr, dma_prg_wrdata and the per-direction write strobe, and returns dma_prg_rddata.
- Holds the software-programmed table base and size, launches the DMA engine on a write to the last-pointer register, and tracks busy/error state.

---
 rtl/dma_desc_hdr_regs.sv | 231 +++++++++++++++++++++++
 tb/tb_dma_desc_hdr_regs.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_hdr_regs.sv
// Descriptor header table register file for one DMA direction.
// Software programs the table size/flags (CTRL), the RC base address
// (BASE_HI/BASE_LO) and then writes LAST to launch the engine. The block
// hands the latched table description to the engine via dt_start/dt_ack,
// tracks busy state and reports sticky launch errors.
//
// Optional build macro: DMA_PRG_WR_LOCK_EN
//   defined   - CTRL/BASE_HI/BASE_LO writes while busy are discarded and
//               flag dt_err[1]; shadow registers stay frozen during a run.
//   undefined - those writes always update the shadow registers.
module dma_desc_hdr_regs #(
  parameter int unsigned MAX_NUMDESC  = 255,
  parameter logic [15:0] RESET_EPLAST = 16'h0
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        dma_prg_wrena,
  input  logic [3:0]  dma_prg_addr,
  input  logic [31:0] dma_prg_wrdata,
  input  logic [3:0]  dma_prg_rdaddr,
  output logic [31:0] dma_prg_rddata,
  output logic [63:0] dt_base_rc,
  output logic [15:0] dt_size,
  output logic [15:0] dt_last,
  output logic        dt_msi,
  output logic        dt_eplast_ena,
  output logic        dt_start,
  input  logic        dt_ack,
  input  logic        dt_done,
  input  logic [15:0] eplast,
  output logic        dt_busy,
  output logic [1:0]  dt_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN
  } state_t;

  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_BASE_HI = 2'd1;
  localparam logic [1:0] SEL_BASE_LO = 2'd2;
  localparam logic [1:0] SEL_LAST    = 2'd3;

  state_t      state_q;
  state_t      state_d;

  // Software-visible shadow registers
  logic [15:0] numdesc_q;
  logic        msi_q;
  logic        eplast_ena_q;
  logic [31:0] base_hi_q;
  logic [31:0] base_lo_q;

  logic [15:0] eplast_q;
  logic [1:0]  rdsel_q;
  logic [31:0] rd_mux;

  logic [1:0]  wr_sel;
  logic        wr_ctrl;
  logic        wr_hi;
  logic        wr_lo;
  logic        wr_last;
  logic        busy_q;
  logic        params_ok;
  logic        launch_try;
  logic        launch_ok;
  logic        launch_bad;
  logic        busy_launch;
  logic        shadow_we;
  logic        lock_err;

  // Address byte-lane bits are not decoded.
  logic        unused_bits;
  assign unused_bits = ^{dma_prg_addr[1:0], dma_prg_rdaddr[1:0]};

  // Write decode and launch qualification
  assign wr_sel      = dma_prg_addr[3:2];
  assign wr_ctrl     = dma_prg_wrena && (wr_sel == SEL_CTRL);
  assign wr_hi       = dma_prg_wrena && (wr_sel == SEL_BASE_HI);
  assign wr_lo       = dma_prg_wrena && (wr_sel == SEL_BASE_LO);
  assign wr_last     = dma_prg_wrena && (wr_sel == SEL_LAST);
  assign busy_q      = (state_q != ST_IDLE);

  assign params_ok   = (numdesc_q != 16'd0) &&
                       ({16'd0, numdesc_q} <= MAX_NUMDESC) &&
                       (dma_prg_wrdata[15:0] < numdesc_q);
  assign launch_try  = wr_last && !busy_q;
  assign launch_ok   = launch_try && params_ok;
  assign launch_bad  = launch_try && !params_ok;
  assign busy_launch = wr_last && busy_q;

`ifdef DMA_PRG_WR_LOCK_EN
  assign shadow_we = !busy_q;
  assign lock_err  = (wr_ctrl || wr_hi || wr_lo) && busy_q;
`else
  assign shadow_we = 1'b1;
  assign lock_err  = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs; done in REQ counts as ack+done
  always_comb begin
    state_d  = state_q;
    dt_start = 1'b0;
    dt_busy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch_ok) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        dt_start = 1'b1;
        dt_busy  = 1'b1;
        if (dt_done) begin
          state_d = ST_IDLE;
        end else if (dt_ack) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        dt_busy = 1'b1;
        if (dt_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shadow register writes; BASE_LO is forced 16-byte aligned
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      numdesc_q    <= '0;
      msi_q        <= 1'b0;
      eplast_ena_q <= 1'b0;
      base_hi_q    <= '0;
      base_lo_q    <= '0;
    end else begin
      if (wr_ctrl && shadow_we) begin
        numdesc_q    <= dma_prg_wrdata[15:0];
        msi_q        <= dma_prg_wrdata[17];
        eplast_ena_q <= dma_prg_wrdata[18];
      end
      if (wr_hi && shadow_we) begin
        base_hi_q <= dma_prg_wrdata;
      end
      if (wr_lo && shadow_we) begin
        base_lo_q <= {dma_prg_wrdata[31:4], 4'h0};
      end
    end
  end

  // Table description handed to the engine, captured only on a valid launch
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dt_base_rc    <= '0;
      dt_size       <= '0;
      dt_last       <= '0;
      dt_msi        <= 1'b0;
      dt_eplast_ena <= 1'b0;
    end else if (launch_ok) begin
      dt_base_rc    <= {base_hi_q, base_lo_q};
      dt_size       <= numdesc_q;
      dt_last       <= dma_prg_wrdata[15:0];
      dt_msi        <= msi_q;
      dt_eplast_ena <= eplast_ena_q;
    end
  end

  // Sticky error flags, cleared only by a valid launch
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dt_err <= '0;
    end else if (launch_ok) begin
      dt_err <= '0;
    end else begin
      if (launch_bad) begin
        dt_err[0] <= 1'b1;
      end
      if (busy_launch || lock_err) begin
        dt_err[1] <= 1'b1;
      end
    end
  end

  // Engine status capture
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      eplast_q <= RESET_EPLAST;
    end else begin
      eplast_q <= eplast;
    end
  end

  // Read mux over the registered address; sees writes from the sampling cycle
  always_comb begin
    rd_mux = '0;
    case (rdsel_q)
      SEL_CTRL:    rd_mux = {dt_busy, 12'd0, eplast_ena_q, msi_q, 1'b0, numdesc_q};
      SEL_BASE_HI: rd_mux = base_hi_q;
      SEL_BASE_LO: rd_mux = base_lo_q;
      SEL_LAST:    rd_mux = {dt_err, 14'd0, eplast_q};
      default:     rd_mux = '0;
    endcase
  end

  // Two-stage read pipeline: address register, then data register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rdsel_q        <= '0;
      dma_prg_rddata <= '0;
    end else begin
      rdsel_q        <= dma_prg_rdaddr[3:2];
      dma_prg_rddata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_dma_desc_hdr_regs.sv
// Self-checking bench for dma_desc_hdr_regs: directed test-plan sequence with
// literal expectations, then randomized traffic, all compared every cycle
// against a behavioural model of the register file and launch handshake.
module tb_dma_desc_hdr_regs;

  localparam int unsigned MAXN = 255;
`ifdef DMA_PRG_WR_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        dma_prg_wrena = 1'b0;
  logic [3:0]  dma_prg_addr = '0;
  logic [31:0] dma_prg_wrdata = '0;
  logic [3:0]  dma_prg_rdaddr = '0;
  logic [31:0] dma_prg_rddata;
  logic [63:0] dt_base_rc;
  logic [15:0] dt_size;
  logic [15:0] dt_last;
  logic        dt_msi;
  logic        dt_eplast_ena;
  logic        dt_start;
  logic        dt_ack = 1'b0;
  logic        dt_done = 1'b0;
  logic [15:0] eplast = 16'h1234;
  logic        dt_busy;
  logic [1:0]  dt_err;

  always #5 clk_in = ~clk_in;

  dma_desc_hdr_regs #(.MAX_NUMDESC(MAXN), .RESET_EPLAST(16'h0)) dut (
    .clk_in(clk_in), .rst(rst),
    .dma_prg_wrena(dma_prg_wrena), .dma_prg_addr(dma_prg_addr),
    .dma_prg_wrdata(dma_prg_wrdata), .dma_prg_rdaddr(dma_prg_rdaddr),
    .dma_prg_rddata(dma_prg_rddata), .dt_base_rc(dt_base_rc),
    .dt_size(dt_size), .dt_last(dt_last), .dt_msi(dt_msi),
    .dt_eplast_ena(dt_eplast_ena), .dt_start(dt_start), .dt_ack(dt_ack),
    .dt_done(dt_done), .eplast(eplast), .dt_busy(dt_busy), .dt_err(dt_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_numdesc;
  logic        m_msi, m_eplena;
  logic [31:0] m_hi, m_lo;
  logic        m_req, m_run;       // request pending / engine running
  logic [1:0]  m_err;
  logic [63:0] m_base;
  logic [15:0] m_size, m_last, m_eplq;
  logic        m_dmsi, m_dena;
  logic [1:0]  m_rda;
  logic [31:0] m_rddata;

  function automatic logic [31:0] readval(input logic [1:0] a);
    case (a)
      2'd0:    return {(m_req | m_run), 12'd0, m_eplena, m_msi, 1'b0, m_numdesc};
      2'd1:    return m_hi;
      2'd2:    return m_lo;
      default: return {m_err, 14'd0, m_eplq};
    endcase
  endfunction

  task automatic model_reset();
    m_numdesc = '0; m_msi = 0; m_eplena = 0; m_hi = '0; m_lo = '0;
    m_req = 0; m_run = 0; m_err = '0; m_base = '0; m_size = '0; m_last = '0;
    m_dmsi = 0; m_dena = 0; m_eplq = 16'h0; m_rda = '0; m_rddata = '0;
  endtask

  task automatic model_step();
    logic [31:0] rd_next;
    logic        was_busy;
    logic [1:0]  sel;
    rd_next  = readval(m_rda);
    was_busy = m_req | m_run;
    sel      = dma_prg_addr[3:2];
    if (m_req) begin
      if (dt_done) m_req = 0;
      else if (dt_ack) begin m_req = 0; m_run = 1; end
    end else if (m_run && dt_done) begin
      m_run = 0;
    end
    if (dma_prg_wrena) begin
      if (sel != 2'd3) begin
        if (was_busy && LOCK) m_err[1] = 1'b1;
        else if (sel == 2'd0) begin
          m_numdesc = dma_prg_wrdata[15:0];
          m_msi     = dma_prg_wrdata[17];
          m_eplena  = dma_prg_wrdata[18];
        end else if (sel == 2'd1) m_hi = dma_prg_wrdata;
        else m_lo = dma_prg_wrdata & 32'hFFFF_FFF0;
      end else if (was_busy) begin
        m_err[1] = 1'b1;
      end else if (m_numdesc >= 1 && m_numdesc <= MAXN &&
                   dma_prg_wrdata[15:0] < m_numdesc) begin
        m_base = {m_hi, m_lo}; m_size = m_numdesc; m_last = dma_prg_wrdata[15:0];
        m_dmsi = m_msi; m_dena = m_eplena; m_err = 2'b00; m_req = 1'b1;
      end else begin
        m_err[0] = 1'b1;
      end
    end
    m_eplq   = eplast;
    m_rda    = dma_prg_rdaddr[3:2];
    m_rddata = rd_next;
  endtask

  always @(posedge clk_in or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk_in) begin
    if (cmp_on) begin
      check("rddata", {32'd0, dma_prg_rddata}, {32'd0, m_rddata});
      check("dt_base_rc", dt_base_rc, m_base);
      check("dt_size", {48'd0, dt_size}, {48'd0, m_size});
      check("dt_last", {48'd0, dt_last}, {48'd0, m_last});
      check("dt_msi", {63'd0, dt_msi}, {63'd0, m_dmsi});
      check("dt_eplast_ena", {63'd0, dt_eplast_ena}, {63'd0, m_dena});
      check("dt_start", {63'd0, dt_start}, {63'd0, m_req});
      check("dt_busy", {63'd0, dt_busy}, {63'd0, (m_req | m_run)});
      check("dt_err", {62'd0, dt_err}, {62'd0, m_err});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    dma_prg_wrena  = 1'b1;
    dma_prg_addr   = a;
    dma_prg_wrdata = d;
    tick();
    dma_prg_wrena  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    dma_prg_rdaddr = a;
    tick();
    tick();
    check(name, {32'd0, dma_prg_rddata}, {32'd0, exp});
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {63'd0, act}, {63'd0, exp});
  endtask

  logic [31:0] ctrl_exp;

  initial begin
    tick(); tick(); tick();
    cmp_on = 1'b1;
    rst = 1'b0;
    tick();
    chk1("rst_start", dt_start, 1'b0);
    chk1("rst_busy", dt_busy, 1'b0);
    check("rst_err", {62'd0, dt_err}, 64'd0);
    check("rst_size", {48'd0, dt_size}, 64'd0);
    rd(4'h0, 32'h0000_0000, "rst_ctrl_rd");
    rd(4'hC, 32'h0000_1234, "rst_last_rd");

    // Read-back
    wr(4'h0, 32'h0006_0004);
    wr(4'h4, 32'h0000_0001);
    wr(4'h8, 32'h2000_001F);
    rd(4'h0, 32'h0006_0004, "rb_ctrl");
    rd(4'h4, 32'h0000_0001, "rb_hi");
    rd(4'h8, 32'h2000_0010, "rb_lo");

    // Bad parameters
    wr(4'h0, 32'h0006_0000);
    wr(4'hC, 32'h0000_0000);
    check("bad_n0_err", {62'd0, dt_err}, 64'd1);
    chk1("bad_n0_start", dt_start, 1'b0);
    wr(4'h0, 32'h0006_0100);
    wr(4'hC, 32'h0000_0000);
    check("bad_n256_err", {62'd0, dt_err}, 64'd1);
    wr(4'h0, 32'h0006_0004);
    wr(4'hC, 32'h0000_0004);
    check("bad_last_err", {62'd0, dt_err}, 64'd1);
    chk1("bad_last_start", dt_start, 1'b0);
    check("bad_last_size", {48'd0, dt_size}, 64'd0);

    // Valid launch clears the error
    wr(4'hC, 32'h0000_0003);
    chk1("go_start", dt_start, 1'b1);
    check("go_size", {48'd0, dt_size}, 64'd4);
    check("go_last", {48'd0, dt_last}, 64'd3);
    check("go_base", dt_base_rc, 64'h0000_0001_2000_0010);
    chk1("go_msi", dt_msi, 1'b1);
    chk1("go_eplena", dt_eplast_ena, 1'b1);
    check("go_err", {62'd0, dt_err}, 64'd0);
    dt_ack = 1'b1;
    tick();
    dt_ack = 1'b0;
    chk1("ack_start", dt_start, 1'b0);
    chk1("ack_busy", dt_busy, 1'b1);

    // Busy collisions
    wr(4'hC, 32'h0000_0001);
    check("coll_err", {62'd0, dt_err}, 64'd2);
    chk1("coll_busy", dt_busy, 1'b1);
    chk1("coll_start", dt_start, 1'b0);
    check("coll_last", {48'd0, dt_last}, 64'd3);
    wr(4'h0, 32'h0000_0008);
    check("coll_size", {48'd0, dt_size}, 64'd4);
    ctrl_exp = LOCK ? 32'h8006_0004 : 32'h8000_0008;
    rd(4'h0, ctrl_exp, "coll_ctrl_rd");
    rd(4'hC, 32'h8000_1234, "coll_stat_rd");
    dt_done = 1'b1;
    tick();
    dt_done = 1'b0;
    chk1("done_busy", dt_busy, 1'b0);

    // Simultaneous ack+done in REQ
    wr(4'h0, 32'h0006_0004);
    wr(4'hC, 32'h0000_0000);
    chk1("ad_start", dt_start, 1'b1);
    check("ad_err", {62'd0, dt_err}, 64'd0);
    dt_ack = 1'b1; dt_done = 1'b1;
    tick();
    dt_ack = 1'b0; dt_done = 1'b0;
    chk1("ad_busy", dt_busy, 1'b0);
    chk1("ad_start0", dt_start, 1'b0);
    tick();
    chk1("ad_busy2", dt_busy, 1'b0);

    // Asynchronous reset mid-run
    wr(4'hC, 32'h0000_0002);
    dt_ack = 1'b1;
    tick();
    dt_ack = 1'b0;
    wr(4'hC, 32'h0000_0001);
    chk1("mr_busy", dt_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("ar_start", dt_start, 1'b0);
    chk1("ar_busy", dt_busy, 1'b0);
    check("ar_err", {62'd0, dt_err}, 64'd0);
    check("ar_base", dt_base_rc, 64'd0);
    check("ar_size", {48'd0, dt_size}, 64'd0);
    check("ar_last", {48'd0, dt_last}, 64'd0);
    chk1("ar_msi", dt_msi, 1'b0);
    chk1("ar_eplena", dt_eplast_ena, 1'b0);
    tick(); tick();
    rst = 1'b0;
    rd(4'h0, 32'h0000_0000, "ar_ctrl_rd");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [15:0] nd;
      dma_prg_wrena  = ($urandom_range(0, 9) < 3);
      dma_prg_addr   = 4'($urandom_range(0, 15));
      dma_prg_rdaddr = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      case (r)
        0:       nd = 16'd0;
        1:       nd = 16'(MAXN);
        2:       nd = 16'(MAXN + 1);
        3:       nd = 16'($urandom);
        default: nd = 16'($urandom_range(1, 8));
      endcase
      if (dma_prg_addr[3:2] == 2'd0)
        dma_prg_wrdata = {16'($urandom), nd};
      else if (dma_prg_addr[3:2] == 2'd3)
        dma_prg_wrdata = {16'($urandom), 16'($urandom_range(0, 9))};
      else
        dma_prg_wrdata = $urandom;
      dt_ack  = ($urandom_range(0, 99) < 35);
      dt_done = ($urandom_range(0, 99) < 12);
      eplast  = 16'($urandom);
      tick();
    end
    dma_prg_wrena = 1'b0; dt_ack = 1'b0; dt_done = 1'b0;
    tick(); tick(); tick();
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
